// File: rtl/ln_pkg.sv
// Shared widths and FSM state encoding for the ln core feeder.
// Imported by ln_fifo and ln_feeder.
package ln_pkg;

   localparam int XW = 16;
   localparam int RW = 18;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/ln_fifo.sv
// Operand queue feeding the ln core; first-word-fall-through read.
// Ports: clk, rst (sync, active-low), push/din, pop/dout, full, empty, level.
module ln_fifo
   import ln_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [XW-1:0] din,
   output logic [XW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [4:0]    level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [4:0] FULL_LVL = 5'(DEPTH);

   logic [XW-1:0] mem_q [DEPTH];
   logic [XW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [4:0]    lvl_q, lvl_d;
   logic          do_push;
   logic          do_pop;

   assign full  = (lvl_q == FULL_LVL);
   assign empty = (lvl_q == 5'd0);
   assign level = lvl_q;
   assign dout  = mem_q[rp_q];

   // Guards make overflow and underflow impossible regardless of callers.
   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      mem_d   = mem_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      lvl_d   = lvl_q;
      if (do_push) begin
         mem_d[wp_q] = din;
         wp_d        = wp_q + 1'b1;
      end
      if (do_pop) begin
         rp_d = rp_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         lvl_d = lvl_q + 5'd1;
      end else if (!do_push && do_pop) begin
         lvl_d = lvl_q - 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         lvl_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         lvl_q <= lvl_d;
      end
   end

   // Storage needs no reset; only words below level are ever read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ln_feeder.sv
// Queues x operands, issues them one at a time to an ln core, captures results.
// Ports: in* push side, core* core handshake, out* result side, busy/err/level status.
module ln_feeder
   import ln_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inValid,
   input  logic [XW-1:0] inData,
   output logic          inReady,
   output logic          coreStart,
   output logic [XW-1:0] coreX,
   input  logic          coreDone,
   input  logic [RW-1:0] coreR,
   output logic          outValid,
   output logic [RW-1:0] outData,
   input  logic          outReady,
   output logic          busy,
   output logic          err,
   output logic [4:0]    level
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [XW-1:0] x_q, x_d;
   logic [RW-1:0] r_q, r_d;
   logic          ov_q, ov_d;
   logic          err_q, err_d;
   logic          rdy_q, rdy_d;

   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [XW-1:0] fifo_dout;
   logic          slot_free;

   ln_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (inValid && inReady),
      .pop  (fifo_pop),
      .din  (inData),
      .dout (fifo_dout),
      .full (fifo_full),
      .empty(fifo_empty),
      .level(level)
   );

   // rdy_q holds inReady low through reset and for the reset edge itself.
   assign rdy_d     = 1'b1;
   assign inReady   = rdy_q && !fifo_full;
   assign slot_free = !ov_q || outReady;

   assign coreX    = x_q;
   assign outValid = ov_q;
   assign outData  = r_q;
   assign err      = err_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         r_q     <= '0;
         ov_q    <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         r_q     <= r_d;
         ov_q    <= ov_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty && slot_free) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (coreDone || cnt_q == TO_LAST) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // coreX is loaded on entry to ISSUE so it is already valid while
   // coreStart is high; the counter starts at 1 so its value equals
   // cycles elapsed since coreStart.
   always_comb begin
      cnt_d = cnt_q;
      x_d   = x_q;
      r_d   = r_q;
      ov_d  = ov_q;
      err_d = err_q;
      if (ov_q && outReady) begin
         ov_d = 1'b0;
      end
      if (state_q == S_IDLE && state_d == S_ISSUE) begin
         x_d = fifo_dout;
      end
      if (state_q == S_ISSUE) begin
         cnt_d = {{(CW-1){1'b0}}, 1'b1};
      end
      if (state_q == S_WAIT) begin
         if (coreDone) begin
            r_d   = coreR;
            ov_d  = 1'b1;
            cnt_d = '0;
         end else if (cnt_q == TO_LAST) begin
            err_d = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      coreStart = 1'b0;
      busy      = 1'b0;
      fifo_pop  = 1'b0;
      unique case (state_q)
         S_ISSUE: begin
            coreStart = 1'b1;
            busy      = 1'b1;
            fifo_pop  = 1'b1;
         end
         S_WAIT: begin
            busy = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_ln_feeder.sv
// Directed bench for ln_feeder with a behavioural ln core model.
// Each task drives one scenario and checks hand-computed values.
module tb_ln_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inValid = 1'b0;
   logic [15:0] inData = '0;
   logic        inReady;
   logic        coreStart;
   logic [15:0] coreX;
   logic        coreDone = 1'b0;
   logic [17:0] coreR = '0;
   logic        outValid;
   logic [17:0] outData;
   logic        outReady = 1'b1;
   logic        busy;
   logic        err;
   logic [4:0]  level;

   int checks = 0;
   int errors = 0;

   int          core_lat = 10;
   bit          core_mute = 1'b0;
   bit          force_done = 1'b0;
   logic [17:0] force_r = '0;
   int          cd = -1;
   logic [15:0] cx = '0;

   always #5 clk = ~clk;

   ln_feeder #(
      .DEPTH(4),
      .TIMEOUT(64)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (inValid),
      .inData   (inData),
      .inReady  (inReady),
      .coreStart(coreStart),
      .coreX    (coreX),
      .coreDone (coreDone),
      .coreR    (coreR),
      .outValid (outValid),
      .outData  (outData),
      .outReady (outReady),
      .busy     (busy),
      .err      (err),
      .level    (level)
   );

   function automatic logic [17:0] core_fn(input logic [15:0] x);
      if (x == 16'hA5A5) return 18'h3A5A5;
      return {2'b00, x} + 18'h07172;
   endfunction

   // ln core model: coreDone rises core_lat cycles after coreStart is seen.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         coreDone = force_done;
         if (force_done) coreR = force_r;
         if (!rst) begin
            cd = -1;
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  coreDone = 1'b1;
                  coreR    = core_fn(cx);
                  cd       = -1;
               end
            end
            if (coreStart && !core_mute) begin
               cx = coreX;
               cd = core_lat;
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst        = 1'b0;
      inValid    = 1'b0;
      outReady   = 1'b1;
      force_done = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      rst      = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      tick();
      tick();
      checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL rst_inReady got %0b want 0", inReady); end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
      checks++; if (coreStart !== 1'b0) begin errors++; $display("FAIL rst_coreStart got %0b want 0", coreStart); end
      checks++; if (coreX !== 16'h0) begin errors++; $display("FAIL rst_coreX got %h want 0", coreX); end
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_outValid got %0b want 0", outValid); end
      checks++; if (outData !== 18'h0) begin errors++; $display("FAIL rst_outData got %h want 0", outData); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", err); end
      rst = 1'b1;
      tick();
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rst_release_inReady got %0b want 1", inReady); end
   endtask

   task automatic test_single;
      int cyc;
      core_mute = 1'b0;
      core_lat  = 10;
      outReady  = 1'b1;
      inValid   = 1'b1;
      inData    = 16'h4000;
      tick();
      inValid = 1'b0;
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
      checks++; if (coreStart !== 1'b0) begin errors++; $display("FAIL single_start_c0 got %0b want 0", coreStart); end
      tick();
      cyc = 1;
      checks++; if (coreStart !== 1'b1) begin errors++; $display("FAIL single_start_c1 got %0b want 1", coreStart); end
      checks++; if (coreX !== 16'h4000) begin errors++; $display("FAIL single_coreX got %h want 4000", coreX); end
      tick();
      cyc = 2;
      checks++; if (coreStart !== 1'b0) begin errors++; $display("FAIL single_start_c2 got %0b want 0", coreStart); end
      while (outValid !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      checks++; if (cyc != 12) begin errors++; $display("FAIL single_latency got %0d want 12", cyc); end
      checks++; if (outData !== 18'h0B172) begin errors++; $display("FAIL single_outData got %h want 0b172", outData); end
      tick();
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL single_handshake got %0b want 0", outValid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %0b want 0", busy); end
   endtask

   task automatic test_full;
      do_reset();
      core_mute = 1'b1;
      for (int i = 0; i < 5; i++) begin
         inValid = 1'b1;
         inData  = 16'h1000 + 16'(i);
         tick();
         if (i == 2) begin
            checks++; if (level !== 5'd2) begin errors++; $display("FAIL full_pushpop_level got %0d want 2", level); end
         end
      end
      checks++; if (level !== 5'd4) begin errors++; $display("FAIL full_level got %0d want 4", level); end
      checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL full_inReady got %0b want 0", inReady); end
      checks++; if (coreX !== 16'h1000) begin errors++; $display("FAIL full_coreX got %h want 1000", coreX); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %0b want 1", busy); end
      inData = 16'hDEAD;
      tick();
      inValid = 1'b0;
      checks++; if (level !== 5'd4) begin errors++; $display("FAIL full_no_overflow got %0d want 4", level); end
   endtask

   task automatic test_backpressure;
      int  cyc;
      bit  saw_start;
      do_reset();
      core_mute = 1'b0;
      core_lat  = 3;
      outReady  = 1'b0;
      inValid   = 1'b1;
      inData    = 16'hFFF0;
      tick();
      inData = 16'hA5A5;
      tick();
      inValid = 1'b0;
      cyc = 0;
      while (outValid !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      checks++; if (outData !== 18'h17162) begin errors++; $display("FAIL bp_first got %h want 17162", outData); end
      saw_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (coreStart === 1'b1) saw_start = 1'b1;
      end
      checks++; if (saw_start !== 1'b0) begin errors++; $display("FAIL bp_withheld got %0b want 0", saw_start); end
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL bp_level got %0d want 1", level); end
      checks++; if (outValid !== 1'b1 || outData !== 18'h17162) begin errors++; $display("FAIL bp_hold got %0b/%h want 1/17162", outValid, outData); end
      outReady = 1'b1;
      tick();
      checks++; if (coreStart !== 1'b1 || coreX !== 16'hA5A5) begin errors++; $display("FAIL bp_resume got %0b/%h want 1/a5a5", coreStart, coreX); end
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL bp_clear got %0b want 0", outValid); end
      cyc = 0;
      while (outValid !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      checks++; if (outData !== 18'h3A5A5) begin errors++; $display("FAIL bp_second got %h want 3a5a5", outData); end
      tick();
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", outValid); end
   endtask

   task automatic test_timeout;
      bit err_early;
      do_reset();
      core_mute = 1'b1;
      inValid   = 1'b1;
      inData    = 16'h1111;
      tick();
      inData = 16'h2222;
      tick();
      inValid = 1'b0;
      checks++; if (coreStart !== 1'b1 || coreX !== 16'h1111) begin errors++; $display("FAIL to_start got %0b/%h want 1/1111", coreStart, coreX); end
      err_early = 1'b0;
      for (int k = 1; k < 64; k++) begin
         tick();
         if (err === 1'b1) err_early = 1'b1;
      end
      checks++; if (err_early !== 1'b0) begin errors++; $display("FAIL to_early got %0b want 0", err_early); end
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got %0b want 1", err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got %0b want 0", busy); end
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL to_no_result got %0b want 0", outValid); end
      tick();
      checks++; if (coreStart !== 1'b1 || coreX !== 16'h2222) begin errors++; $display("FAIL to_next got %0b/%h want 1/2222", coreStart, coreX); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b want 1", err); end
   endtask

   task automatic test_reset_mid_wait;
      do_reset();
      core_mute = 1'b1;
      inValid   = 1'b1;
      inData    = 16'h0123;
      tick();
      inValid = 1'b0;
      tick();
      tick();
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mw_in_wait got %0b want 1", busy); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++; if (coreX !== 16'h0 || level !== 5'd0) begin errors++; $display("FAIL mw_rst_x_lvl got %h/%0d want 0/0", coreX, level); end
      checks++; if (inReady !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mw_rst_rdy_busy got %0b/%0b want 0/0", inReady, busy); end
      force_done = 1'b1;
      force_r    = 18'h2AAAA;
      tick();
      force_done = 1'b0;
      tick();
      tick();
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL mw_outValid got %0b want 0", outValid); end
      checks++; if (outData !== 18'h0) begin errors++; $display("FAIL mw_outData got %h want 0", outData); end
      checks++; if (coreStart !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mw_ctrl got %0b/%0b/%0b want 0/0/0", coreStart, busy, err); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_backpressure();
      test_timeout();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
